// File: rtl/float_argmin_scan.sv
// Streaming IEEE-754 min/argmin over a run of len elements; one element per cycle, result
// registered one cycle after the last accept. Input is consumed only while running & in0_valid.
module float_argmin_scan #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8,
   parameter int IDX_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              running,
   input  logic              run,
   input  logic [IDX_W-1:0]  len,
   input  logic [DATA_W-1:0] in0,
   input  logic              in0_valid,
   output logic              done,
   output logic [DATA_W-1:0] out0,
   output logic [IDX_W-1:0]  out1,
   output logic              found
);

   localparam int MAN_W = DATA_W - 1 - EXP_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DATA_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

   logic [1:0]        state;
   logic [IDX_W-1:0]  len_q;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] best;
   logic [IDX_W-1:0]  best_idx;
   logic              best_valid;

   logic              in_nan;
   logic              accept;
   logic              upd;
   logic              last;
   logic [DATA_W-1:0] nxt_best;
   logic [IDX_W-1:0]  nxt_best_idx;
   logic              nxt_best_valid;

   // Sign-magnitude order on raw bits, so -0 sorts below +0.
   function automatic logic f_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W-2:0] ma;
      logic [DATA_W-2:0] mb;
      ma = a[DATA_W-2:0];
      mb = b[DATA_W-2:0];
      if (a[DATA_W-1] != b[DATA_W-1])
         return a[DATA_W-1];
      else if (a[DATA_W-1])
         return ma > mb;
      else
         return ma < mb;
   endfunction

   always_comb begin
      in_nan         = (&in0[DATA_W-2 -: EXP_W]) && (|in0[MAN_W-1:0]);
      accept         = (state == S_SCAN) && running && in0_valid;
      upd            = accept && !in_nan && (!best_valid || f_lt(in0, best));
      last           = (idx == len_q - IDX_ONE);
      nxt_best       = upd ? in0 : best;
      nxt_best_idx   = upd ? idx : best_idx;
      nxt_best_valid = best_valid | upd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         len_q      <= '0;
         idx        <= '0;
         best       <= '0;
         best_idx   <= '0;
         best_valid <= 1'b0;
         done       <= 1'b0;
         out0       <= '0;
         out1       <= '0;
         found      <= 1'b0;
      end else if (run) begin
         len_q      <= len;
         idx        <= '0;
         best_valid <= 1'b0;
         if (len == '0) begin
            // Empty run completes immediately with the "nothing found" result.
            state <= S_DONE;
            done  <= 1'b1;
            out0  <= QNAN;
            out1  <= '1;
            found <= 1'b0;
         end else begin
            state <= S_SCAN;
            done  <= 1'b0;
         end
      end else begin
         case (state)
            S_SCAN: begin
               if (accept) begin
                  idx        <= idx + IDX_ONE;
                  best       <= nxt_best;
                  best_idx   <= nxt_best_idx;
                  best_valid <= nxt_best_valid;
                  if (last) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     found <= nxt_best_valid;
                     out0  <= nxt_best_valid ? nxt_best : QNAN;
                     out1  <= nxt_best_valid ? nxt_best_idx : '1;
                  end
               end
            end
            S_IDLE, S_DONE: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_argmin_scan.sv
// Directed-vector bench for float_argmin_scan with hand-computed expected results.
module tb_float_argmin_scan;

   logic        clk;
   logic        rst;
   logic        running;
   logic        run;
   logic [15:0] len;
   logic [31:0] in0;
   logic        in0_valid;
   logic        done;
   logic [31:0] out0;
   logic [15:0] out1;
   logic        found;

   int n_cmp;
   int n_err;

   float_argmin_scan #(.DATA_W(32), .EXP_W(8), .IDX_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .running   (running),
      .run       (run),
      .len       (len),
      .in0       (in0),
      .in0_valid (in0_valid),
      .done      (done),
      .out0      (out0),
      .out1      (out1),
      .found     (found)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Inputs change on the falling edge; outputs are read there too, half a cycle after the rising edge.
   task automatic do_run(input logic [15:0] l);
      run = 1'b1;
      len = l;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic feed(input logic [31:0] v);
      in0       = v;
      in0_valid = 1'b1;
      @(negedge clk);
      in0_valid = 1'b0;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [31:0] e0, input logic [15:0] e1,
                               input logic ef);
      check_val({tag, "_done"},  {31'd0, done},  32'd1);
      check_val({tag, "_out0"},  out0,           e0);
      check_val({tag, "_out1"},  {16'd0, out1},  {16'd0, e1});
      check_val({tag, "_found"}, {31'd0, found}, {31'd0, ef});
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      running   = 1'b1;
      run       = 1'b0;
      len       = '0;
      in0       = '0;
      in0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_val("rst_done",  {31'd0, done},  32'd0);
      check_val("rst_out0",  out0,           32'd0);
      check_val("rst_out1",  {16'd0, out1},  32'd0);
      check_val("rst_found", {31'd0, found}, 32'd0);

      // 1: {3.0, -1.5, 2.0, -1.5}, first -1.5 wins
      do_run(16'd4);
      feed(32'h4040_0000);
      feed(32'hBFC0_0000);
      feed(32'h4000_0000);
      check_val("t1_done_early", {31'd0, done}, 32'd0);
      feed(32'hBFC0_0000);
      check_result("t1", 32'hBFC0_0000, 16'd1, 1'b1);

      // 2: NaN, +0, -0 -> -0 at index 2
      do_run(16'd3);
      check_val("t2_done_fall", {31'd0, done}, 32'd0);
      check_val("t2_out0_hold", out0, 32'hBFC0_0000);
      feed(32'h7FC0_0001);
      feed(32'h0000_0000);
      feed(32'h8000_0000);
      check_result("t2", 32'h8000_0000, 16'd2, 1'b1);

      // 3: all NaN (positive and negative)
      do_run(16'd2);
      feed(32'h7FC0_0001);
      feed(32'hFF80_0001);
      check_result("t3", 32'h7FC0_0000, 16'hFFFF, 1'b0);

      // 4: len=0 then len=1 with -inf; valid input in DONE is ignored
      do_run(16'd0);
      check_result("t4a", 32'h7FC0_0000, 16'hFFFF, 1'b0);
      feed(32'hBF80_0000);
      feed(32'hBF80_0000);
      check_result("t4_ignore", 32'h7FC0_0000, 16'hFFFF, 1'b0);
      do_run(16'd1);
      feed(32'hFF80_0000);
      check_result("t4b", 32'hFF80_0000, 16'd0, 1'b1);

      // 5: stall with running low; the offered -1.0 must never be taken
      do_run(16'd5);
      feed(32'h40A0_0000);
      feed(32'h4080_0000);
      running = 1'b0;
      for (int i = 0; i < 3; i++) feed(32'hBF80_0000);
      running = 1'b1;
      @(negedge clk);
      check_val("t5_stall_done", {31'd0, done}, 32'd0);
      feed(32'h7F80_0000);
      feed(32'h3F80_0000);
      check_val("t5_done_early", {31'd0, done}, 32'd0);
      feed(32'h3F80_0000);
      check_result("t5", 32'h3F80_0000, 16'd3, 1'b1);

      // 6: abort a len=8 scan after 3 elements, restart with len=2
      do_run(16'd8);
      feed(32'h3F80_0000);
      feed(32'h3F80_0000);
      feed(32'h3F80_0000);
      do_run(16'd2);
      check_val("t6_no_done_abort", {31'd0, done}, 32'd0);
      feed(32'h40E0_0000);
      check_val("t6_done_early", {31'd0, done}, 32'd0);
      feed(32'h40C0_0000);
      check_result("t6", 32'h40C0_0000, 16'd1, 1'b1);

      // 7: reset mid-scan, then elements without run stay in IDLE
      do_run(16'd4);
      feed(32'h4000_0000);
      feed(32'h4000_0000);
      do_rst();
      check_val("t7_done",  {31'd0, done},  32'd0);
      check_val("t7_out0",  out0,           32'd0);
      check_val("t7_out1",  {16'd0, out1},  32'd0);
      check_val("t7_found", {31'd0, found}, 32'd0);
      for (int i = 0; i < 4; i++) feed(32'h4000_0000);
      check_val("t7_idle_done", {31'd0, done}, 32'd0);
      check_val("t7_idle_out0", out0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
